// File: rtl/vend_pkg.sv
// Shared types, coin encodings and price lookup for the vending controller.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } vend_state_e;

   localparam int CREDIT_W = 6;

   localparam logic [1:0]          COIN_5  = 2'b01;
   localparam logic [1:0]          COIN_10 = 2'b10;
   localparam logic [CREDIT_W-1:0] VAL_5   = 6'd5;
   localparam logic [CREDIT_W-1:0] VAL_10  = 6'd10;

   function automatic logic [CREDIT_W-1:0] price_lookup(
      input logic [1:0]          sel,
      input logic [CREDIT_W-1:0] p0,
      input logic [CREDIT_W-1:0] p1,
      input logic [CREDIT_W-1:0] p2,
      input logic [CREDIT_W-1:0] p3
   );
      logic [CREDIT_W-1:0] price;
      case (sel)
         2'd0:    price = p0;
         2'd1:    price = p1;
         2'd2:    price = p2;
         default: price = p3;
      endcase
      return price;
   endfunction

endpackage

// File: rtl/vend_change_sequencer.sv
// Pays back a loaded credit one coin per handshake, largest coin first.
module vend_change_sequencer
   import vend_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [CREDIT_W-1:0] load_i,
   input  logic                chg_ack_i,
   output logic                chg_req_o,
   output logic                chg_coin_o,
   output logic                done_o,
   output logic [CREDIT_W-1:0] remaining_o
);

   logic [CREDIT_W-1:0] rem_q, rem_d;
   logic                req_q, req_d;
   logic                coin_q, coin_d;
   logic [CREDIT_W-1:0] step_s;

   // Next remaining credit and coin choice after a load or an acknowledged coin
   always_comb begin
      rem_d  = rem_q;
      req_d  = req_q;
      coin_d = coin_q;
      step_s = coin_q ? VAL_10 : VAL_5;
      if (start_i) begin
         rem_d  = load_i;
         req_d  = (load_i != 6'd0);
         coin_d = (load_i >= VAL_10);
      end else if (req_q && chg_ack_i) begin
         rem_d  = (rem_q >= step_s) ? (rem_q - step_s) : 6'd0;
         req_d  = (rem_d != 6'd0);
         coin_d = (rem_d >= VAL_10);
      end else begin
         rem_d  = rem_q;
      end
   end

   // Sequencer state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= 6'd0;
         req_q  <= 1'b0;
         coin_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         req_q  <= req_d;
         coin_q <= coin_d;
      end
   end

   // Finished once no further coin is owed after this cycle
   assign done_o      = ~req_d;
   assign chg_req_o   = req_q;
   assign chg_coin_o  = coin_q;
   assign remaining_o = rem_q;

endmodule

// File: rtl/vend_controller.sv
// Vending controller: coin collection, selection validation, dispense handshake
// and change hand-off to the change sequencer.
module vend_controller
   import vend_pkg::*;
#(
   parameter int PRICE0     = 15,
   parameter int PRICE1     = 20,
   parameter int PRICE2     = 25,
   parameter int PRICE3     = 30,
   parameter int CREDIT_MAX = 40,
   parameter int TIMEOUT    = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_valid,
   input  logic [1:0] coin,
   input  logic       sel_valid,
   input  logic [1:0] sel,
   input  logic       cancel,
   output logic       disp_req,
   output logic [1:0] disp_id,
   input  logic       disp_ack,
   output logic       chg_req,
   output logic       chg_coin,
   input  logic       chg_ack,
   output logic [5:0] credit,
   output logic       busy,
   output logic       coin_reject,
   output logic       sel_reject
);

   localparam logic [CREDIT_W-1:0] P0_C      = PRICE0[CREDIT_W-1:0];
   localparam logic [CREDIT_W-1:0] P1_C      = PRICE1[CREDIT_W-1:0];
   localparam logic [CREDIT_W-1:0] P2_C      = PRICE2[CREDIT_W-1:0];
   localparam logic [CREDIT_W-1:0] P3_C      = PRICE3[CREDIT_W-1:0];
   localparam logic [CREDIT_W:0]   CMAX_C    = CREDIT_MAX[CREDIT_W:0];
   localparam logic [7:0]          TIMEOUT_C = TIMEOUT[7:0];

   vend_state_e         state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                disp_req_q, disp_req_d;
   logic [1:0]          disp_id_q, disp_id_d;
   logic                coin_rej_q, coin_rej_d;
   logic                sel_rej_q, sel_rej_d;

   logic                coin_ok_s, coin_acc_s;
   logic [CREDIT_W-1:0] coin_val_s, acc_s, price_s;
   logic [CREDIT_W:0]   sum_s;
   logic                seq_start_s, seq_done_s;
   logic [CREDIT_W-1:0] seq_load_s, seq_rem_s;

   // Coin qualification: sum is one bit wider so an over-limit coin cannot wrap
   always_comb begin
      coin_ok_s  = coin_valid && ((coin == COIN_5) || (coin == COIN_10));
      coin_val_s = (coin == COIN_10) ? VAL_10 : VAL_5;
      sum_s      = {1'b0, credit_q} + {1'b0, coin_val_s};
      coin_acc_s = coin_ok_s && (sum_s <= CMAX_C);
      acc_s      = coin_acc_s ? sum_s[CREDIT_W-1:0] : credit_q;
      price_s    = price_lookup(sel, P0_C, P1_C, P2_C, P3_C);
   end

   // Next-state, credit, idle counter and pulse outputs
   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      cnt_d       = 8'd0;
      disp_req_d  = disp_req_q;
      disp_id_d   = disp_id_q;
      coin_rej_d  = 1'b0;
      sel_rej_d   = 1'b0;
      seq_start_s = 1'b0;
      seq_load_s  = 6'd0;
      case (state_q)
         ST_IDLE: begin
            coin_rej_d = coin_valid && !coin_acc_s;
            sel_rej_d  = sel_valid;
            if (coin_acc_s) begin
               credit_d = acc_s;
               state_d  = ST_COLLECT;
            end else begin
               credit_d = 6'd0;
            end
         end
         ST_COLLECT: begin
            coin_rej_d = coin_valid && !coin_acc_s;
            if (cancel) begin
               seq_start_s = 1'b1;
               seq_load_s  = acc_s;
               credit_d    = 6'd0;
               state_d     = ST_CHANGE;
            end else if (sel_valid) begin
               // Selection is judged on the credit held before any same-cycle coin
               if (credit_q >= price_s) begin
                  disp_req_d = 1'b1;
                  disp_id_d  = sel;
                  credit_d   = acc_s - price_s;
                  state_d    = ST_DISPENSE;
               end else begin
                  sel_rej_d = 1'b1;
                  credit_d  = acc_s;
               end
            end else if (coin_valid) begin
               credit_d = acc_s;
            end else if ((cnt_q + 8'd1) >= TIMEOUT_C) begin
               seq_start_s = 1'b1;
               seq_load_s  = credit_q;
               credit_d    = 6'd0;
               state_d     = ST_CHANGE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DISPENSE: begin
            coin_rej_d = coin_valid;
            sel_rej_d  = sel_valid;
            if (disp_ack) begin
               disp_req_d = 1'b0;
               if (credit_q == 6'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  seq_start_s = 1'b1;
                  seq_load_s  = credit_q;
                  credit_d    = 6'd0;
                  state_d     = ST_CHANGE;
               end
            end else begin
               state_d = ST_DISPENSE;
            end
         end
         ST_CHANGE: begin
            coin_rej_d = coin_valid;
            sel_rej_d  = sel_valid;
            if (seq_done_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CHANGE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            credit_d   = 6'd0;
            disp_req_d = 1'b0;
         end
      endcase
   end

   // Controller state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         credit_q   <= 6'd0;
         cnt_q      <= 8'd0;
         disp_req_q <= 1'b0;
         disp_id_q  <= 2'd0;
         coin_rej_q <= 1'b0;
         sel_rej_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         cnt_q      <= cnt_d;
         disp_req_q <= disp_req_d;
         disp_id_q  <= disp_id_d;
         coin_rej_q <= coin_rej_d;
         sel_rej_q  <= sel_rej_d;
      end
   end

   vend_change_sequencer u_change (
      .clk         (clk),
      .rst         (rst),
      .start_i     (seq_start_s),
      .load_i      (seq_load_s),
      .chg_ack_i   (chg_ack),
      .chg_req_o   (chg_req),
      .chg_coin_o  (chg_coin),
      .done_o      (seq_done_s),
      .remaining_o (seq_rem_s)
   );

   // While paying change the sequencer owns the credit
   assign credit      = (state_q == ST_CHANGE) ? seq_rem_s : credit_q;
   assign busy        = (state_q == ST_DISPENSE) || (state_q == ST_CHANGE);
   assign disp_req    = disp_req_q;
   assign disp_id     = disp_id_q;
   assign coin_reject = coin_rej_q;
   assign sel_reject  = sel_rej_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with hand-computed expectations.
module tb_vend_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_valid, sel_valid, cancel, disp_ack, chg_ack;
   logic [1:0] coin, sel;
   logic       disp_req, chg_req, chg_coin, busy, coin_reject, sel_reject;
   logic [1:0] disp_id;
   logic [5:0] credit;

   int total = 0;
   int bad   = 0;

   vend_controller dut (
      .clk         (clk),
      .rst         (rst),
      .coin_valid  (coin_valid),
      .coin        (coin),
      .sel_valid   (sel_valid),
      .sel         (sel),
      .cancel      (cancel),
      .disp_req    (disp_req),
      .disp_id     (disp_id),
      .disp_ack    (disp_ack),
      .chg_req     (chg_req),
      .chg_coin    (chg_coin),
      .chg_ack     (chg_ack),
      .credit      (credit),
      .busy        (busy),
      .coin_reject (coin_reject),
      .sel_reject  (sel_reject)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input int unsigned obs, input int unsigned exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs applied before the call are seen at this edge
   task automatic tick();
      @(posedge clk);
      #1;
      coin_valid = 1'b0;
      sel_valid  = 1'b0;
      cancel     = 1'b0;
      disp_ack   = 1'b0;
      chg_ack    = 1'b0;
   endtask

   task automatic put_coin(input logic [1:0] c);
      coin_valid = 1'b1;
      coin       = c;
      tick();
   endtask

   task automatic put_sel(input logic [1:0] s);
      sel_valid = 1'b1;
      sel       = s;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
      disp_ack = 1'b0; chg_ack = 1'b0; coin = 2'b00; sel = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_credit", credit, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_disp_req", disp_req, 0);
      chk_eq("rst_disp_id", disp_id, 0);
      chk_eq("rst_chg_req", chg_req, 0);
      chk_eq("rst_chg_coin", chg_coin, 0);
      chk_eq("rst_rejects", {coin_reject, sel_reject}, 0);
      rst = 1'b0;

      // 10+10, buy product 0 (15), 5 back
      put_coin(2'b10);
      chk_eq("t1_credit10", credit, 10);
      put_coin(2'b10);
      chk_eq("t1_credit20", credit, 20);
      put_sel(2'd0);
      chk_eq("t1_disp_req", disp_req, 1);
      chk_eq("t1_disp_id", disp_id, 0);
      chk_eq("t1_busy", busy, 1);
      chk_eq("t1_credit5", credit, 5);
      tick();
      chk_eq("t1_disp_hold", disp_req, 1);
      disp_ack = 1'b1; tick();
      chk_eq("t1_disp_drop", disp_req, 0);
      chk_eq("t1_chg_req", chg_req, 1);
      chk_eq("t1_chg_coin", chg_coin, 0);
      chk_eq("t1_chg_credit", credit, 5);
      chg_ack = 1'b1; tick();
      chk_eq("t1_end_req", chg_req, 0);
      chk_eq("t1_end_credit", credit, 0);
      chk_eq("t1_end_busy", busy, 0);

      // insufficient credit; coin accepted alongside a rejected selection
      put_coin(2'b01);
      put_coin(2'b01);
      put_sel(2'd1);
      chk_eq("t2_sel_rej", sel_reject, 1);
      chk_eq("t2_credit10", credit, 10);
      tick();
      chk_eq("t2_sel_rej_pulse", sel_reject, 0);
      coin_valid = 1'b1; coin = 2'b10; sel_valid = 1'b1; sel = 2'd1; tick();
      chk_eq("t2_both_sel_rej", sel_reject, 1);
      chk_eq("t2_both_coin_ok", coin_reject, 0);
      chk_eq("t2_both_credit", credit, 20);
      chk_eq("t2_both_busy", busy, 0);
      cancel = 1'b1; tick();
      chk_eq("t2_chg_coin10", chg_coin, 1);
      chg_ack = 1'b1; tick();
      chk_eq("t2_credit_after1", credit, 10);
      chg_ack = 1'b1; tick();
      chk_eq("t2_idle", {busy, chg_req}, 0);

      // credit ceiling, invalid code, full refund of 40
      put_coin(2'b10); put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
      chk_eq("t3_credit35", credit, 35);
      put_coin(2'b10);
      chk_eq("t3_over_rej", coin_reject, 1);
      chk_eq("t3_over_credit", credit, 35);
      put_coin(2'b01);
      chk_eq("t3_rej_pulse", coin_reject, 0);
      chk_eq("t3_credit40", credit, 40);
      put_coin(2'b11);
      chk_eq("t3_bad_code", coin_reject, 1);
      chk_eq("t3_bad_credit", credit, 40);
      cancel = 1'b1; tick();
      chk_eq("t3_chg_req", chg_req, 1);
      chk_eq("t3_credit_chg", credit, 40);
      tick();
      chk_eq("t3_no_ack_hold", credit, 40);
      for (int k = 0; k < 4; k++) begin
         chk_eq("t3_coin10", chg_coin, 1);
         chg_ack = 1'b1; tick();
         chk_eq("t3_refund_credit", credit, 30 - 10 * k);
         chk_eq("t3_refund_req", chg_req, (k < 3) ? 1 : 0);
      end
      chk_eq("t3_idle", busy, 0);

      // idle timeout with 5 credit
      put_coin(2'b01);
      repeat (254) tick();
      chk_eq("t4_before_to", busy, 0);
      chk_eq("t4_before_req", chg_req, 0);
      tick();
      chk_eq("t4_at_to", busy, 1);
      chk_eq("t4_chg_req", chg_req, 1);
      chk_eq("t4_chg_coin", chg_coin, 0);
      chk_eq("t4_credit", credit, 5);
      chg_ack = 1'b1; tick();
      chk_eq("t4_idle", {busy, chg_req, credit}, 0);

      // exact payment: dispense straight back to idle
      put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
      put_sel(2'd3);
      chk_eq("t5_disp_req", disp_req, 1);
      chk_eq("t5_disp_id", disp_id, 3);
      chk_eq("t5_credit0", credit, 0);
      put_coin(2'b01);
      chk_eq("t5_coin_rej", coin_reject, 1);
      chk_eq("t5_credit_still0", credit, 0);
      put_sel(2'd0);
      chk_eq("t5_sel_rej", sel_reject, 1);
      chk_eq("t5_disp_hold", disp_req, 1);
      disp_ack = 1'b1; tick();
      chk_eq("t5_after_ack", {busy, disp_req, chg_req, credit}, 0);
      tick();
      chk_eq("t5_no_chg", chg_req, 0);

      // reset in the middle of change
      put_coin(2'b10); put_coin(2'b10);
      cancel = 1'b1; tick();
      chk_eq("t6_chg_credit", credit, 20);
      chk_eq("t6_chg_req", chg_req, 1);
      #2;
      rst = 1'b1;
      #1;
      chk_eq("t6_async_req", chg_req, 0);
      chk_eq("t6_async_busy", busy, 0);
      chk_eq("t6_async_credit", credit, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk_eq("t6_post_idle", {busy, chg_req, credit}, 0);
      put_coin(2'b01);
      chk_eq("t6_post_coin", credit, 5);
      chk_eq("t6_post_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
